// File: rtl/multi_sprite_core.sv
// multi_sprite_core
//   Sprite overlay for the video pipeline. Up to eight 16x16 sprites, each with
//   four 2-bit-per-pixel animation frames, a 3-entry palette, horizontal mirror
//   and tick-driven frame stepping. Fixed-priority compositor (lowest index wins)
//   keyed on pixel index 0, two-cycle latency from (x, y, si_rgb) to so_rgb.
//
//   Optional feature macro: SPRITE_COLLISION_EN (sticky per-sprite collision
//   flags with write-1-to-clear). When undefined, coll_status is tied to 0.
//
// Ports
//   clk          system clock
//   reset_n      synchronous active-low reset
//   x, y         current pixel coordinate (11 bits each)
//   cs, write    slot select / write strobe; a write is cs & write
//   addr         14-bit slot word address
//   wr_data      32-bit write data
//   si_rgb       incoming stream pixel (CD bits)
//   so_rgb       outgoing stream pixel (CD bits, registered)
//   coll_status  sticky collision flags, one per sprite
//
// Address map
//   addr[13]=0            pixel RAM: [12:10] sprite, [9:8] frame, [7:4] row, [3:0] col
//   addr[13]=1, addr[6]=0 sprite regs: [5:3] sprite, [2:0] reg
//                         0 x0, 1 y0, 2 ctrl {animate, frame[1:0], mirror, enable},
//                         3 period, 4..6 palette for index 1..3, 7 reserved
//   addr[13]=1, addr[6]=1 global: addr[0]=0 bypass, addr[0]=1 collision clear
module multi_sprite_core #(
    parameter int CD          = 12,
    parameter int NUM_SPRITES = 4,
    parameter int KEY_COLOR   = 0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [10:0]            x,
    input  logic [10:0]            y,
    input  logic                   cs,
    input  logic                   write,
    input  logic [13:0]            addr,
    input  logic [31:0]            wr_data,
    input  logic [CD-1:0]          si_rgb,
    output logic [CD-1:0]          so_rgb,
    output logic [NUM_SPRITES-1:0] coll_status
);

    localparam int NS = NUM_SPRITES;
    localparam logic [1:0] KEY = 2'(KEY_COLOR);

    // ---------------------------------------------------------------
    // Write decode
    // ---------------------------------------------------------------
    logic          we;
    logic          glob_we;
    logic [NS-1:0] pix_sel;
    logic [NS-1:0] spr_sel;

    assign we      = cs & write;
    assign glob_we = we & addr[13] & addr[6];

    always_comb begin
        pix_sel = '0;
        spr_sel = '0;
        for (int i = 0; i < NS; i++) begin
            pix_sel[i] = we & ~addr[13] & (addr[12:10] == 3'(i));
            spr_sel[i] = we & addr[13] & ~addr[6] & (addr[5:3] == 3'(i));
        end
    end

    // Only some wr_data bits are consumed, depending on CD and the build.
    logic unused_wr_bits;
    assign unused_wr_bits = &{1'b0, wr_data};

    // ---------------------------------------------------------------
    // Registers and animation state
    // ---------------------------------------------------------------
    logic [10:0]   x0         [NS];
    logic [10:0]   y0         [NS];
    logic [4:0]    ctrl       [NS];
    logic [7:0]    period     [NS];
    logic [CD-1:0] pal        [NS][3];
    logic [7:0]    anim_cnt   [NS];
    logic [1:0]    anim_frame [NS];
    logic [7:0]    anim_last  [NS];
    logic          bypass;

    logic origin;
    logic prev_origin;
    logic frame_tick;

    // Edge-detect on entering (0,0) so a slow pixel clock holding the origin
    // for several clk cycles produces exactly one tick.
    assign origin     = (x == 11'd0) && (y == 11'd0);
    assign frame_tick = origin & ~prev_origin;

    always_comb begin
        for (int i = 0; i < NS; i++) begin
            anim_last[i] = (period[i] == 8'd0) ? 8'd0 : period[i] - 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bypass      <= 1'b0;
            prev_origin <= 1'b0;
            for (int i = 0; i < NS; i++) begin
                x0[i]         <= '0;
                y0[i]         <= '0;
                ctrl[i]       <= '0;
                period[i]     <= '0;
                pal[i][0]     <= '0;
                pal[i][1]     <= '0;
                pal[i][2]     <= '0;
                anim_cnt[i]   <= '0;
                anim_frame[i] <= '0;
            end
        end else begin
            prev_origin <= origin;
            if (glob_we && !addr[0]) begin
                bypass <= wr_data[0];
            end
            for (int i = 0; i < NS; i++) begin
                if (spr_sel[i]) begin
                    case (addr[2:0])
                        3'd0:    x0[i]     <= wr_data[10:0];
                        3'd1:    y0[i]     <= wr_data[10:0];
                        3'd2:    ctrl[i]   <= wr_data[4:0];
                        3'd3:    period[i] <= wr_data[7:0];
                        3'd4:    pal[i][0] <= wr_data[CD-1:0];
                        3'd5:    pal[i][1] <= wr_data[CD-1:0];
                        3'd6:    pal[i][2] <= wr_data[CD-1:0];
                        default: ;
                    endcase
                end
                // A period write outranks a coincident tick: counter restarts,
                // frame stays. The animate bit used here is the pre-write value.
                if (spr_sel[i] && (addr[2:0] == 3'd3)) begin
                    anim_cnt[i] <= '0;
                end else if (frame_tick && ctrl[i][4]) begin
                    if (anim_cnt[i] == anim_last[i]) begin
                        anim_cnt[i]   <= '0;
                        anim_frame[i] <= anim_frame[i] + 2'd1;
                    end else begin
                        anim_cnt[i] <= anim_cnt[i] + 8'd1;
                    end
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // Stage 1: hit test and RAM address
    // ---------------------------------------------------------------
    logic [10:0]        dx  [NS];
    logic [10:0]        dy  [NS];
    logic [3:0]         col [NS];
    logic [1:0]         frm [NS];
    logic [NS-1:0]      hit;
    logic [NS-1:0][9:0] rd_addr;

    always_comb begin
        hit     = '0;
        rd_addr = '0;
        for (int i = 0; i < NS; i++) begin
            dx[i]  = x - x0[i];
            dy[i]  = y - y0[i];
            // x >= x0 rejects the modular wrap that dx alone would allow.
            hit[i] = ctrl[i][0] && (x >= x0[i]) && (dx[i][10:4] == 7'd0)
                                && (y >= y0[i]) && (dy[i][10:4] == 7'd0);
            col[i] = ctrl[i][1] ? ~dx[i][3:0] : dx[i][3:0];
            frm[i] = ctrl[i][4] ? anim_frame[i] : ctrl[i][3:2];
            rd_addr[i] = {frm[i], dy[i][3:0], col[i]};
        end
    end

    logic [NS-1:0]      hit_q;
    logic [CD-1:0]      si_q;
    logic [NS-1:0][1:0] pix_rd;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hit_q <= '0;
            si_q  <= '0;
        end else begin
            hit_q <= hit;
            si_q  <= si_rgb;
        end
    end

    // One RAM per sprite; read-before-write gives old data on a same-cycle
    // collision. Contents are deliberately not reset.
    for (genvar g = 0; g < NS; g++) begin : g_ram
        logic [1:0] mem [1024];
        logic [1:0] rd_q;

        always_ff @(posedge clk) begin
            if (pix_sel[g]) begin
                mem[addr[9:0]] <= wr_data[1:0];
            end
            rd_q <= mem[rd_addr[g]];
        end

        assign pix_rd[g] = rd_q;
    end

    // ---------------------------------------------------------------
    // Stage 2: palette lookup, priority and blend
    // ---------------------------------------------------------------
    logic [NS-1:0] opaque;
    logic          any_opaque;
    logic [CD-1:0] win_rgb;

    always_comb begin
        opaque     = '0;
        any_opaque = 1'b0;
        win_rgb    = '0;
        for (int i = 0; i < NS; i++) begin
            opaque[i] = hit_q[i] && (pix_rd[i] != KEY);
        end
        // Walk downward so the lowest opaque index is the last to assign.
        for (int i = NS - 1; i >= 0; i--) begin
            if (opaque[i]) begin
                any_opaque = 1'b1;
                case (pix_rd[i])
                    2'd1:    win_rgb = pal[i][0];
                    2'd2:    win_rgb = pal[i][1];
                    default: win_rgb = pal[i][2];
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            so_rgb <= '0;
        end else if (bypass || !any_opaque) begin
            so_rgb <= si_q;
        end else begin
            so_rgb <= win_rgb;
        end
    end

`ifdef SPRITE_COLLISION_EN
    logic [3:0]    n_opaque;
    logic [NS-1:0] coll_clr;

    always_comb begin
        n_opaque = '0;
        for (int i = 0; i < NS; i++) begin
            n_opaque = n_opaque + {3'd0, opaque[i]};
        end
    end

    assign coll_clr = (glob_we && addr[0]) ? wr_data[NS-1:0] : '0;

    // Clear is applied first so a simultaneous set survives.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            coll_status <= '0;
        end else begin
            coll_status <= (coll_status & ~coll_clr)
                         | ((n_opaque >= 4'd2) ? opaque : '0);
        end
    end
`else
    assign coll_status = '0;
`endif

endmodule

// File: tb/tb_multi_sprite_core.sv
module tb_multi_sprite_core;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [10:0] x;
    logic [10:0] y;
    logic        cs;
    logic        write;
    logic [13:0] addr;
    logic [31:0] wr_data;
    logic [11:0] si_rgb;
    logic [11:0] so_rgb;
    logic [3:0]  coll_status;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    multi_sprite_core dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .x           (x),
        .y           (y),
        .cs          (cs),
        .write       (write),
        .addr        (addr),
        .wr_data     (wr_data),
        .si_rgb      (si_rgb),
        .so_rgb      (so_rgb),
        .coll_status (coll_status)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [13:0] a, input logic [31:0] d);
        cs      = 1'b1;
        write   = 1'b1;
        addr    = a;
        wr_data = d;
        step();
        cs      = 1'b0;
        write   = 1'b0;
    endtask

    function automatic logic [13:0] reg_a(input int s, input int r);
        return 14'(32'h2000 + s * 8 + r);
    endfunction

    function automatic logic [13:0] pix_a(input int s, input int f, input int r, input int c);
        return 14'(s * 1024 + f * 256 + r * 16 + c);
    endfunction

    // Present a coordinate and pixel, wait the two-cycle latency, compare.
    task automatic pix(input string tag, input int px, input int py,
                       input logic [31:0] si, input logic [31:0] exp);
        x      = 11'(px);
        y      = 11'(py);
        si_rgb = 12'(si);
        step();
        step();
        check(tag, 32'(so_rgb), exp);
    endtask

    task automatic do_tick();
        x = 11'd0;
        y = 11'd0;
        repeat (4) step();
        x = 11'd1000;
        y = 11'd1000;
        step();
    endtask

    initial begin
        reset_n = 1'b0;
        x       = 11'd1000;
        y       = 11'd1000;
        cs      = 1'b0;
        write   = 1'b0;
        addr    = '0;
        wr_data = '0;
        si_rgb  = 12'hABC;

        // Reset and defaults
        step();
        step();
        check("rst_so", 32'(so_rgb), 32'h0);
        check("rst_coll", 32'(coll_status), 32'h0);
        reset_n = 1'b1;
        step();
        check("rst_lat1", 32'(so_rgb), 32'h0);
        step();
        check("rst_lat2", 32'(so_rgb), 32'hABC);

        for (int s = 0; s < 4; s++)
            for (int a = 0; a < 1024; a++)
                wr(14'(s * 1024 + a), 32'h0);

        // Placement, palette and mirror
        wr(pix_a(0, 0, 0, 0), 1);
        wr(reg_a(0, 0), 100);
        wr(reg_a(0, 1), 50);
        wr(reg_a(0, 4), 32'hF00);
        wr(reg_a(0, 2), 32'h01);
        pix("place_hit",   100, 50, 32'hABC, 32'hF00);
        pix("place_next",  101, 50, 32'h123, 32'h123);
        pix("place_left",   99, 50, 32'h456, 32'h456);
        pix("place_row1",  100, 51, 32'h789, 32'h789);
        wr(reg_a(0, 2), 32'h03);
        pix("mirror_hit",  115, 50, 32'hABC, 32'hF00);
        pix("mirror_orig", 100, 50, 32'h321, 32'h321);

        // Boundary at the right edge
        for (int c = 0; c < 16; c++) wr(pix_a(0, 0, 0, c), 1);
        wr(reg_a(0, 0), 2040);
        wr(reg_a(0, 2), 32'h01);
        pix("bnd_2040",  2040, 50, 32'h111, 32'hF00);
        pix("bnd_2047",  2047, 50, 32'h112, 32'hF00);
        pix("bnd_wrap0",    0, 50, 32'h222, 32'h222);
        pix("bnd_wrap7",    7, 50, 32'h333, 32'h333);
        wr(reg_a(0, 2), 32'h00);

        // Priority between sprites 1 and 2
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) begin
                wr(pix_a(1, 0, r, c), 1);
                wr(pix_a(2, 0, r, c), 1);
            end
        for (int s = 1; s < 3; s++) begin
            wr(reg_a(s, 0), 300);
            wr(reg_a(s, 1), 200);
            wr(reg_a(s, 2), 32'h01);
        end
        wr(reg_a(1, 4), 32'h0F0);
        wr(reg_a(2, 4), 32'h00F);
        pix("prio_both",    300, 200, 32'h555, 32'h0F0);
        pix("prio_corner",  315, 215, 32'h555, 32'h0F0);
        pix("prio_outside", 316, 215, 32'h556, 32'h556);
`ifdef SPRITE_COLLISION_EN
        check("coll_prio", 32'(coll_status), 32'h6);
        wr(14'h2041, 32'hF);
        step();
        check("coll_prio_clr", 32'(coll_status), 32'h0);
`endif
        wr(reg_a(1, 2), 32'h00);
        pix("prio_s2",  305, 207, 32'h555, 32'h00F);
        wr(pix_a(2, 0, 0, 0), 2);
        wr(reg_a(2, 5), 32'h0AA);
        pix("pal_idx2", 300, 200, 32'h555, 32'h0AA);
        wr(14'h2040, 1);
        pix("bypass",   300, 200, 32'h777, 32'h777);
        wr(14'h2040, 0);
        pix("unbypass", 300, 200, 32'h777, 32'h0AA);
        wr(reg_a(2, 2), 32'h00);

        // Animation on sprite 3: frame f shows pixel index f at (row 0, col 0)
        wr(pix_a(3, 1, 0, 0), 1);
        wr(pix_a(3, 2, 0, 0), 2);
        wr(pix_a(3, 3, 0, 0), 3);
        wr(reg_a(3, 4), 32'h111);
        wr(reg_a(3, 5), 32'h222);
        wr(reg_a(3, 6), 32'h333);
        wr(reg_a(3, 0), 500);
        wr(reg_a(3, 1), 400);
        wr(reg_a(3, 3), 3);
        wr(reg_a(3, 2), 32'h11);
        pix("anim_t0", 500, 400, 32'h0C0, 32'h0C0);
        do_tick();
        pix("anim_t1", 500, 400, 32'h0C1, 32'h0C1);
        do_tick();
        do_tick();
        pix("anim_t3", 500, 400, 32'h0C2, 32'h111);
        do_tick();
        do_tick();
        pix("anim_t5", 500, 400, 32'h0C3, 32'h111);
        do_tick();
        pix("anim_t6", 500, 400, 32'h0C4, 32'h222);
        do_tick();
        pix("anim_t7", 500, 400, 32'h0C5, 32'h222);
        do_tick();
        // Tick 9 coincides with a period write.
        x = 11'd0;
        y = 11'd0;
        wr(reg_a(3, 3), 3);
        repeat (3) step();
        x = 11'd1000;
        y = 11'd1000;
        step();
        pix("anim_t9", 500, 400, 32'h0C6, 32'h222);
        do_tick();
        do_tick();
        pix("anim_t11", 500, 400, 32'h0C7, 32'h222);
        do_tick();
        pix("anim_t12", 500, 400, 32'h0C8, 32'h333);
        wr(reg_a(3, 2), 32'h05);
        pix("anim_static", 500, 400, 32'h0C9, 32'h111);
        do_tick();
        pix("static_hold", 500, 400, 32'h0CA, 32'h111);

        // Overlap of sprites 0 and 3
        wr(reg_a(0, 0), 500);
        wr(reg_a(0, 1), 400);
        wr(reg_a(0, 2), 32'h01);
        pix("coll_out", 500, 400, 32'h999, 32'hF00);
`ifdef SPRITE_COLLISION_EN
        check("coll_set", 32'(coll_status), 32'h9);
        x = 11'd1000;
        y = 11'd1000;
        step();
        step();
        check("coll_sticky", 32'(coll_status), 32'h9);
        wr(14'h2041, 32'h1);
        step();
        check("coll_clr", 32'(coll_status), 32'h8);
`else
        check("coll_off", 32'(coll_status), 32'h0);
        wr(14'h2041, 32'hF);
        step();
        check("coll_off_clr", 32'(coll_status), 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
